// File: rtl/stage_writeback_if.sv
// stage_writeback_if
//  Bundles the MEM-to-writeback result handshake, the data-memory response
//  and the register-file write port / status outputs of stage_writeback.
//  Parameters:
//   CNT_W  width of the retired-instruction counter
//  Modports:
//   master  upstream side (MEM stage / memory / register file consumer):
//           drives the in_* signals and observes the out_* signals
//   slave   stage_writeback itself
interface stage_writeback_if #(
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_write_mem_to_reg;
    logic             in_write_enable;
    logic [4:0]       in_rd;
    logic [31:0]      in_alu_result;
    logic [2:0]       in_funct3;
    logic             in_mem_rsp_valid;
    logic [31:0]      in_mem_rsp_data;
    logic             out_ready;
    logic             out_write_enable;
    logic [4:0]       out_write_reg;
    logic [31:0]      out_write_data;
    logic             out_timeout;
    logic             out_spurious_rsp;
    logic [CNT_W-1:0] out_retired_count;

    modport master (
        output in_valid, in_write_mem_to_reg, in_write_enable, in_rd,
               in_alu_result, in_funct3, in_mem_rsp_valid, in_mem_rsp_data,
        input  out_ready, out_write_enable, out_write_reg, out_write_data,
               out_timeout, out_spurious_rsp, out_retired_count
    );

    modport slave (
        input  in_valid, in_write_mem_to_reg, in_write_enable, in_rd,
               in_alu_result, in_funct3, in_mem_rsp_valid, in_mem_rsp_data,
        output out_ready, out_write_enable, out_write_reg, out_write_data,
               out_timeout, out_spurious_rsp, out_retired_count
    );
endinterface

// File: rtl/stage_writeback.sv
// stage_writeback
//  Final pipeline stage. Accepts MEM-stage results, waits for variable-latency
//  load data, sign/zero-extends loads and drives the register-file write port.
//  MEM is back-pressured (out_ready low) while a load is outstanding; a load
//  that sees no response within MEM_TIMEOUT cycles is abandoned and flagged.
//  Ports:
//   clk    clock, all state on posedge
//   reset  synchronous, active-high
//   wb     stage_writeback_if.slave: in_* result/response inputs,
//          out_ready, out_write_enable/reg/data, out_timeout,
//          out_spurious_rsp, out_retired_count
//  Parameters:
//   MEM_TIMEOUT  max cycles waiting for load data (>=1)
//   CNT_W        retired-instruction counter width
//  Configuration macro:
//   WB_RETIRE_CNT_EN  when defined, the retired-instruction counter is built;
//                     otherwise out_retired_count is tied to zero.
module stage_writeback #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    stage_writeback_if.slave wb
);

    localparam int TMR_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    // Timer value on the last waiting edge; the load is dropped there if no response arrives.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state_r;
    logic             ready_r;
    logic             we_r;
    logic [4:0]       reg_r;
    logic [31:0]      data_r;
    logic             timeout_r;
    logic             spurious_r;
    logic [TMR_W-1:0] timer_r;
    logic [4:0]       ld_rd_r;
    logic [2:0]       ld_funct3_r;
    logic [1:0]       ld_addr_r;
    logic             ld_we_r;

    // Select byte/halfword from the aligned word and extend according to funct3.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [2:0]  funct3,
        input logic [1:0]  addr
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (addr)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        if (addr[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (funct3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = word;   // undefined widths behave as a full-word load
        endcase
        return res;
    endfunction

    // Main sequencer: handshake, load wait/timeout, write-port and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b1;
            we_r        <= 1'b0;
            reg_r       <= 5'd0;
            data_r      <= 32'd0;
            timeout_r   <= 1'b0;
            spurious_r  <= 1'b0;
            timer_r     <= '0;
            ld_rd_r     <= 5'd0;
            ld_funct3_r <= 3'd0;
            ld_addr_r   <= 2'd0;
            ld_we_r     <= 1'b0;
        end else begin
            we_r <= 1'b0;   // write strobe is a single-cycle pulse
            case (state_r)
                ST_IDLE: begin
                    // Nothing is outstanding, so any response here is unsolicited.
                    if (wb.in_mem_rsp_valid) begin
                        spurious_r <= 1'b1;
                    end
                    if (wb.in_valid) begin
                        if (wb.in_write_mem_to_reg) begin
                            ld_rd_r     <= wb.in_rd;
                            ld_funct3_r <= wb.in_funct3;
                            ld_addr_r   <= wb.in_alu_result[1:0];
                            ld_we_r     <= wb.in_write_enable;
                            timer_r     <= '0;
                            state_r     <= ST_WAIT;
                            ready_r     <= 1'b0;
                        end else if (wb.in_write_enable && (wb.in_rd != 5'd0)) begin
                            we_r   <= 1'b1;
                            reg_r  <= wb.in_rd;
                            data_r <= wb.in_alu_result;
                        end
                    end
                end
                ST_WAIT: begin
                    // A response on the expiry edge still completes the load.
                    if (wb.in_mem_rsp_valid) begin
                        if (ld_we_r && (ld_rd_r != 5'd0)) begin
                            we_r   <= 1'b1;
                            reg_r  <= ld_rd_r;
                            data_r <= load_extend(wb.in_mem_rsp_data, ld_funct3_r, ld_addr_r);
                        end
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                    end else if (timer_r == TMR_LAST) begin
                        timeout_r <= 1'b1;
                        state_r   <= ST_IDLE;
                        ready_r   <= 1'b1;
                    end else begin
                        timer_r <= timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign wb.out_ready        = ready_r;
    assign wb.out_write_enable = we_r;
    assign wb.out_write_reg    = reg_r;
    assign wb.out_write_data   = data_r;
    assign wb.out_timeout      = timeout_r;
    assign wb.out_spurious_rsp = spurious_r;

`ifdef WB_RETIRE_CNT_EN
    logic             retire_s;
    logic [CNT_W-1:0] cnt_r;

    // An instruction retires when an ALU result is accepted or a load response arrives.
    always_comb begin
        retire_s = 1'b0;
        if (state_r == ST_IDLE) begin
            retire_s = wb.in_valid && !wb.in_write_mem_to_reg;
        end else begin
            retire_s = wb.in_mem_rsp_valid;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (retire_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign wb.out_retired_count = cnt_r;
`else
    assign wb.out_retired_count = '0;
`endif

endmodule

// File: tb/tb_stage_writeback.sv
module tb_stage_writeback;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    logic clk;
    logic reset;
    logic chk_en;
    int   total;
    int   bad;

    stage_writeback_if #(.CNT_W(CNT_W)) bus ();

    stage_writeback #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the outputs must be after the latest edge.
    logic             exp_ready, exp_we, exp_to, exp_sp;
    logic [4:0]       exp_reg;
    logic [31:0]      exp_data;
    logic [CNT_W-1:0] exp_cnt;
    bit               m_busy;
    int               m_wait;
    logic [4:0]       m_rd;
    logic [2:0]       m_f3;
    int unsigned      m_addr;
    logic             m_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext(input logic [31:0] word, input logic [2:0] f3,
                                        input int unsigned addr);
        logic [31:0] b;
        logic [31:0] h;
        b = (word >> (8 * addr)) & 32'hFF;
        h = (word >> (16 * (addr / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    task automatic retire();
`ifdef WB_RETIRE_CNT_EN
        exp_cnt = exp_cnt + 1;
`endif
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        if (reset) begin
            m_busy = 0; m_wait = 0;
            exp_ready = 1'b1; exp_we = 1'b0; exp_reg = 5'd0; exp_data = 32'd0;
            exp_to = 1'b0; exp_sp = 1'b0; exp_cnt = '0;
        end else begin
            exp_we = 1'b0;
            if (!m_busy) begin
                if (bus.in_mem_rsp_valid) exp_sp = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in_write_mem_to_reg) begin
                        m_busy = 1; m_wait = 0;
                        m_rd = bus.in_rd; m_f3 = bus.in_funct3;
                        m_addr = bus.in_alu_result % 4; m_we = bus.in_write_enable;
                    end else begin
                        if (bus.in_write_enable && bus.in_rd != 0) begin
                            exp_we = 1'b1; exp_reg = bus.in_rd; exp_data = bus.in_alu_result;
                        end
                        retire();
                    end
                end
            end else begin
                m_wait++;
                if (bus.in_mem_rsp_valid) begin
                    if (m_we && m_rd != 0) begin
                        exp_we = 1'b1; exp_reg = m_rd;
                        exp_data = ext(bus.in_mem_rsp_data, m_f3, m_addr);
                    end
                    retire();
                    m_busy = 0;
                end else if (m_wait == MEM_TIMEOUT) begin
                    exp_to = 1'b1;
                    m_busy = 0;
                end
            end
            exp_ready = !m_busy;
        end
    endtask

    // One clock: drive inputs at negedge, update model at posedge, return #1 later.
    task automatic cyc(input logic rst, input logic v, input logic m2r, input logic we,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [2:0] f3,
                       input logic rv, input logic [31:0] rdata);
        @(negedge clk);
        reset = rst;
        bus.in_valid = v; bus.in_write_mem_to_reg = m2r; bus.in_write_enable = we;
        bus.in_rd = rd; bus.in_alu_result = alu; bus.in_funct3 = f3;
        bus.in_mem_rsp_valid = rv; bus.in_mem_rsp_data = rdata;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 1'b0, 32'd0);
    endtask

    // Compare process: every cycle, all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", {31'd0, bus.out_ready}, {31'd0, exp_ready});
            check("we", {31'd0, bus.out_write_enable}, {31'd0, exp_we});
            check("reg", {27'd0, bus.out_write_reg}, {27'd0, exp_reg});
            check("data", bus.out_write_data, exp_data);
            check("timeout", {31'd0, bus.out_timeout}, {31'd0, exp_to});
            check("spurious", {31'd0, bus.out_spurious_rsp}, {31'd0, exp_sp});
            check("count", bus.out_retired_count, exp_cnt);
        end
    end

    initial begin
        logic [CNT_W-1:0] c0;
        total = 0; bad = 0; chk_en = 1'b0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_write_mem_to_reg = 1'b0; bus.in_write_enable = 1'b0;
        bus.in_rd = 5'd0; bus.in_alu_result = 32'd0; bus.in_funct3 = 3'd0;
        bus.in_mem_rsp_valid = 1'b0; bus.in_mem_rsp_data = 32'd0;

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 1'b0, 32'd0);
        chk_en = 1'b1;
        check("rst_ready", {31'd0, bus.out_ready}, 32'd1);
        check("rst_we", {31'd0, bus.out_write_enable}, 32'd0);
        check("rst_flags", {30'd0, bus.out_timeout, bus.out_spurious_rsp}, 32'd0);
        check("rst_count", bus.out_retired_count, 32'd0);

        // ALU op rd=5
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 3'd0, 1'b0, 32'd0);
        check("alu_we", {31'd0, bus.out_write_enable}, 32'd1);
        check("alu_reg", {27'd0, bus.out_write_reg}, 32'd5);
        check("alu_data", bus.out_write_data, 32'h1234_5678);
        idle();
        check("alu_pulse", {31'd0, bus.out_write_enable}, 32'd0);
        check("alu_hold", bus.out_write_data, 32'h1234_5678);

        // Back-to-back ALU ops
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b1, 5'(i), 32'(i * 16), 3'd0, 1'b0, 32'd0);
            check("b2b_we", {31'd0, bus.out_write_enable}, 32'd1);
            check("b2b_reg", {27'd0, bus.out_write_reg}, 32'(i));
            check("b2b_ready", {31'd0, bus.out_ready}, 32'd1);
        end
        idle();

        // LB, addr[1:0]=2, response 4 cycles after acceptance
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0000_1002, 3'b000, 1'b0, 32'd0);
        check("lb_ready0", {31'd0, bus.out_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("lb_wait_ready", {31'd0, bus.out_ready}, 32'd0);
            check("lb_wait_we", {31'd0, bus.out_write_enable}, 32'd0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 32'h0080_FF00);
        check("lb_we", {31'd0, bus.out_write_enable}, 32'd1);
        check("lb_reg", {27'd0, bus.out_write_reg}, 32'd7);
        check("lb_data", bus.out_write_data, 32'hFFFF_FF80);
        check("lb_ready1", {31'd0, bus.out_ready}, 32'd1);

        // LHU and LH at addr 2
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 32'h0000_0002, 3'b101, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 32'h8001_0000);
        check("lhu_data", bus.out_write_data, 32'h0000_8001);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_0002, 3'b001, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 32'h8001_0000);
        check("lh_data", bus.out_write_data, 32'hFFFF_8001);

        // Timeout: no response for MEM_TIMEOUT cycles
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 5'd10, 32'h0000_0000, 3'b010, 1'b0, 32'd0);
        for (int i = 1; i < MEM_TIMEOUT; i++) idle();
        check("to_before_ready", {31'd0, bus.out_ready}, 32'd0);
        check("to_before_flag", {31'd0, bus.out_timeout}, 32'd0);
        idle();
        check("to_flag", {31'd0, bus.out_timeout}, 32'd1);
        check("to_ready", {31'd0, bus.out_ready}, 32'd1);
        check("to_no_write", {31'd0, bus.out_write_enable}, 32'd0);

        // rd=0 ALU op and spurious response in IDLE
        c0 = bus.out_retired_count;
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 3'd0, 1'b0, 32'd0);
        check("rd0_we", {31'd0, bus.out_write_enable}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
        check("rd0_count", bus.out_retired_count, c0 + 32'd1);
`else
        check("rd0_count", bus.out_retired_count, 32'd0);
`endif
        check("sp_before", {31'd0, bus.out_spurious_rsp}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 32'h1111_1111);
        check("sp_flag", {31'd0, bus.out_spurious_rsp}, 32'd1);

        // Randomized traffic, with occasional resets (including mid-load)
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom % 300) == 0, $urandom % 2 == 0, $urandom % 2 == 0,
                $urandom % 4 != 0, 5'($urandom % 32), $urandom, 3'($urandom % 8),
                $urandom % 5 == 0, $urandom);
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
